// File: rtl/mem_golden_checker_pkg.sv
// Shared types and defaults for the post-halt data-memory versus golden-image checker.
// Holds the scan state encoding, default geometry and the mismatch-counter helpers.
package checker_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CMP  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_WORDS  = 1024;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam int ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // The mismatch counter sticks at all-ones instead of wrapping back to a passing-looking value.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
    return (value == ERR_MAX) ? value : value + ERR_W'(1);
  endfunction

endpackage

// File: rtl/mem_golden_checker_mis_record_reg.sv
// Mismatch record holding register with a valid/ready output handshake.
// A record loads on a compare miss and stays frozen until the consumer takes it.
module mis_record_reg #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_dut,
  input  logic [DATA_W-1:0] load_gold,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_dut,
  output logic [DATA_W-1:0] rec_gold,
  output logic              fire
);

  assign fire = valid && ready;

  // Fields are only written on load, so they cannot move while a record is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      rec_addr <= '0;
      rec_dut  <= '0;
      rec_gold <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      rec_addr <= load_addr;
      rec_dut  <= load_dut;
      rec_gold <= load_gold;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_golden_checker.sv
// Walks data memory word by word after the CPU halts and compares each word with the golden image.
// Every miss is emitted as an address/data record; done and pass summarise the scan.
module mem_golden_checker
  import checker_pkg::*;
#(
  parameter int WORDS         = DEF_WORDS,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic              mis_valid,
  input  logic              mis_ready,
  output logic [ADDR_W-1:0] mis_addr,
  output logic [DATA_W-1:0] mis_dut,
  output logic [DATA_W-1:0] mis_gold,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam bit STOP = (STOP_ON_FIRST != 0);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [ERR_W-1:0]  errs;
  logic              is_last;
  logic              mismatch;
  logic              start_ok;
  logic              rec_load;
  logic              rec_fire;
  logic              advance;

  assign is_last  = (addr == LAST_ADDR);
  assign mismatch = (dut_rdata != gold_rdata);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Stop is checked against the last word rather than relying on the counter wrapping.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = READ;
      READ: next_state = CMP;
      CMP: begin
        if (mismatch)     next_state = EMIT;
        else if (is_last) next_state = DONE;
        else              next_state = READ;
      end
      EMIT: begin
        if (rec_fire) next_state = (STOP || is_last) ? DONE : READ;
      end
      DONE: if (start) next_state = READ;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = (state == READ);
    busy     = (state == READ) || (state == CMP) || (state == EMIT);
    done     = (state == DONE);
    pass     = (state == DONE) && (errs == '0);
    rec_load = (state == CMP) && mismatch;
    advance  = ((state == CMP) && !mismatch && !is_last) ||
               ((state == EMIT) && rec_fire && !STOP && !is_last);
  end

  // A start accepted from IDLE or DONE rewinds the scan; start while busy changes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      errs <= '0;
    end else if (start_ok) begin
      addr <= '0;
      errs <= '0;
    end else begin
      if (rec_load) errs <= sat_inc(errs);
      if (advance)  addr <= addr + ADDR_W'(1);
    end
  end

  assign rd_addr   = addr;
  assign err_count = errs;

  mis_record_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_record (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rec_load),
    .load_addr (addr),
    .load_dut  (dut_rdata),
    .load_gold (gold_rdata),
    .ready     (mis_ready),
    .valid     (mis_valid),
    .rec_addr  (mis_addr),
    .rec_dut   (mis_dut),
    .rec_gold  (mis_gold),
    .fire      (rec_fire)
  );

endmodule

// File: tb/tb_mem_golden_checker.sv
// Directed bench for mem_golden_checker: a 16-word scanner with a spare address bit,
// plus a stop-on-first instance, both fed by small behavioural memories.
module tb_mem_golden_checker;

  localparam int W = 16;

  typedef struct {
    logic [15:0] mask;
    logic [31:0] flip;
    bit          unit5;
    int          exp_err;
    logic        exp_pass;
    int          exp_cycle;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic sel;
  logic mis_ready;
  logic start0;
  logic start1;

  logic [31:0] gold_mem [W];
  logic [31:0] dut_mem  [W];

  logic        d0_rd_en, d0_mis_valid, d0_busy, d0_done, d0_pass;
  logic [4:0]  d0_rd_addr, d0_mis_addr;
  logic [31:0] d0_dut_rdata, d0_gold_rdata, d0_mis_dut, d0_mis_gold;
  logic [15:0] d0_err;

  logic        d1_rd_en, d1_mis_valid, d1_busy, d1_done, d1_pass;
  logic [3:0]  d1_rd_addr, d1_mis_addr;
  logic [31:0] d1_dut_rdata, d1_gold_rdata, d1_mis_dut, d1_mis_gold;
  logic [15:0] d1_err;

  logic        c_rd_en, c_mis_valid, c_busy, c_done, c_pass;
  logic [4:0]  c_rd_addr, c_mis_addr;
  logic [31:0] c_mis_dut, c_mis_gold;
  logic [15:0] c_err;

  int n_checks = 0;
  int n_fails  = 0;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  mem_golden_checker #(.WORDS(W), .ADDR_W(5), .DATA_W(32), .STOP_ON_FIRST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rd_en(d0_rd_en), .rd_addr(d0_rd_addr),
    .dut_rdata(d0_dut_rdata), .gold_rdata(d0_gold_rdata), .mis_valid(d0_mis_valid),
    .mis_ready(mis_ready), .mis_addr(d0_mis_addr), .mis_dut(d0_mis_dut), .mis_gold(d0_mis_gold),
    .busy(d0_busy), .done(d0_done), .pass(d0_pass), .err_count(d0_err)
  );

  mem_golden_checker #(.WORDS(W), .ADDR_W(4), .DATA_W(32), .STOP_ON_FIRST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_en(d1_rd_en), .rd_addr(d1_rd_addr),
    .dut_rdata(d1_dut_rdata), .gold_rdata(d1_gold_rdata), .mis_valid(d1_mis_valid),
    .mis_ready(mis_ready), .mis_addr(d1_mis_addr), .mis_dut(d1_mis_dut), .mis_gold(d1_mis_gold),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .err_count(d1_err)
  );

  // One-cycle read latency memories shared by both scanners.
  initial begin
    d0_dut_rdata = '0; d0_gold_rdata = '0; d1_dut_rdata = '0; d1_gold_rdata = '0;
  end
  always @(posedge clk) begin
    if (d0_rd_en) begin
      d0_dut_rdata  <= dut_mem[d0_rd_addr[3:0]];
      d0_gold_rdata <= gold_mem[d0_rd_addr[3:0]];
    end
    if (d1_rd_en) begin
      d1_dut_rdata  <= dut_mem[d1_rd_addr];
      d1_gold_rdata <= gold_mem[d1_rd_addr];
    end
  end

  assign c_rd_en     = sel ? d1_rd_en     : d0_rd_en;
  assign c_rd_addr   = sel ? {1'b0, d1_rd_addr}  : d0_rd_addr;
  assign c_mis_valid = sel ? d1_mis_valid : d0_mis_valid;
  assign c_mis_addr  = sel ? {1'b0, d1_mis_addr} : d0_mis_addr;
  assign c_mis_dut   = sel ? d1_mis_dut   : d0_mis_dut;
  assign c_mis_gold  = sel ? d1_mis_gold  : d0_mis_gold;
  assign c_busy      = sel ? d1_busy      : d0_busy;
  assign c_done      = sel ? d1_done      : d0_done;
  assign c_pass      = sel ? d1_pass      : d0_pass;
  assign c_err       = sel ? d1_err       : d0_err;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic loadMem(input logic [15:0] mask, input logic [31:0] flip);
    for (int i = 0; i < W; i++) begin
      gold_mem[i] = 32'h1357_0000 | 32'(i);
      dut_mem[i]  = mask[i] ? (gold_mem[i] ^ flip) : gold_mem[i];
    end
  endtask

  // Leaves the bench #1 after the edge that accepts start, i.e. in cycle 1 of the scan.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runScan(input string tag, input logic [15:0] exp_mask, input int limit,
                         output int done_cycle, output int nrec);
    int  cyc;
    int  prev;
    int  e;
    bit  first_ok;
    bit  range_ok;
    applyStimulus();
    cyc = 1; prev = -1; nrec = 0; first_ok = 1'b0; range_ok = 1'b1;
    while (cyc <= limit) begin
      @(negedge clk);
      if (c_done) break;
      if (cyc == 1) first_ok = c_rd_en && (c_rd_addr == 5'd0);
      if (c_rd_en && (c_rd_addr >= 5'(W))) range_ok = 1'b0;
      if (c_mis_valid && mis_ready) begin
        e = 0;
        for (int k = prev + 1; k < W; k++) begin
          if (exp_mask[k]) begin
            e = k;
            break;
          end
        end
        checkOutput({tag, " rec addr"}, 32'(c_mis_addr), 32'(e));
        checkOutput({tag, " rec dut"},  c_mis_dut,  dut_mem[e]);
        checkOutput({tag, " rec gold"}, c_mis_gold, gold_mem[e]);
        prev = e;
        nrec++;
      end
      @(posedge clk);
      cyc++;
    end
    done_cycle = cyc;
    checkOutput({tag, " done"}, 32'(c_done), 32'd1);
    checkOutput({tag, " first read at word 0"}, 32'(first_ok), 32'd1);
    checkOutput({tag, " rd_addr within WORDS"}, 32'(range_ok), 32'd1);
  endtask

  // Holds a record for ten cycles with mis_ready low, then accepts it.
  task automatic stallRecord(input string tag, input int exp_addr);
    bit ok;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (c_mis_valid) break;
    end
    checkOutput({tag, " valid arrives"}, 32'(c_mis_valid), 32'd1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!c_mis_valid || c_done || (c_mis_addr != 5'(exp_addr)) ||
          (c_mis_dut != dut_mem[exp_addr]) || (c_mis_gold != gold_mem[exp_addr])) ok = 1'b0;
    end
    checkOutput({tag, " stable during stall"}, 32'(ok), 32'd1);
    checkOutput({tag, " addr"}, 32'(c_mis_addr), 32'(exp_addr));
    mis_ready = 1'b1;
    @(posedge clk);
    #1 mis_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " valid drops"}, 32'(c_mis_valid), 32'd0);
  endtask

  vec_t vecs [4];

  initial begin
    int done_cycle;
    int nrec;
    int arrive;

    vecs[0] = '{mask: 16'h0000, flip: 32'h0,         unit5: 1'b0, exp_err: 0,  exp_pass: 1'b1, exp_cycle: 33};
    vecs[1] = '{mask: 16'h0020, flip: 32'h0,         unit5: 1'b1, exp_err: 1,  exp_pass: 1'b0, exp_cycle: 34};
    vecs[2] = '{mask: 16'h0200, flip: 32'h8000_0000, unit5: 1'b0, exp_err: 1,  exp_pass: 1'b0, exp_cycle: 34};
    vecs[3] = '{mask: 16'hFFFF, flip: 32'h0F0F_0001, unit5: 1'b0, exp_err: 16, exp_pass: 1'b0, exp_cycle: 49};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; mis_ready = 1'b0;
    loadMem(16'h0000, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset d0 control", {26'd0, d0_rd_en, d0_mis_valid, d0_busy, d0_done, d0_pass, 1'b0}, 32'd0);
    checkOutput("reset d0 addrs", {22'd0, d0_rd_addr, d0_mis_addr}, 32'd0);
    checkOutput("reset d0 data", d0_mis_dut | d0_mis_gold, 32'd0);
    checkOutput("reset d0 err_count", 32'(d0_err), 32'd0);
    checkOutput("reset d1 all", {d1_rd_en, d1_mis_valid, d1_busy, d1_done, d1_pass, d1_rd_addr, d1_mis_addr, d1_err}
                                | d1_mis_dut | d1_mis_gold, 32'd0);
    rst_n = 1'b1;

    mis_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      loadMem(vecs[v].mask, vecs[v].flip);
      if (vecs[v].unit5) begin
        gold_mem[5] = 32'h0000_0001;
        dut_mem[5]  = 32'h0000_0000;
      end
      runScan($sformatf("vec%0d", v), vecs[v].mask, 200, done_cycle, nrec);
      checkOutput($sformatf("vec%0d done cycle", v), 32'(done_cycle), 32'(vecs[v].exp_cycle));
      checkOutput($sformatf("vec%0d records", v), 32'(nrec), 32'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d err_count", v), 32'(c_err), 32'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d pass", v), 32'(c_pass), 32'(vecs[v].exp_pass));
      checkOutput($sformatf("vec%0d busy after done", v), 32'(c_busy), 32'd0);
    end

    // Misses at the first and last word, each stalled by the consumer.
    mis_ready = 1'b0;
    loadMem(16'h8001, 32'hFFFF_FFFF);
    applyStimulus();
    stallRecord("stall w0", 0);
    checkOutput("stall busy between records", 32'(c_busy), 32'd1);
    stallRecord("stall w15", 15);
    checkOutput("stall done after last", 32'(c_done), 32'd1);
    checkOutput("stall err_count", 32'(c_err), 32'd2);
    checkOutput("stall pass", 32'(c_pass), 32'd0);

    // Stop-on-first instance only reports word 3.
    sel = 1'b1;
    mis_ready = 1'b1;
    loadMem(16'h0088, 32'h0000_00FF);
    runScan("stop", 16'h0088, 200, done_cycle, nrec);
    checkOutput("stop done cycle", 32'(done_cycle), 32'd10);
    checkOutput("stop records", 32'(nrec), 32'd1);
    checkOutput("stop err_count", 32'(c_err), 32'd1);
    checkOutput("stop pass", 32'(c_pass), 32'd0);

    // Restart attempt mid-scan, then an asynchronous reset while a record is pending.
    sel = 1'b0;
    mis_ready = 1'b0;
    loadMem(16'h0020, 32'h0000_0100);
    applyStimulus();
    arrive = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 4);
      if (c_mis_valid) begin
        arrive = cyc;
        break;
      end
      @(posedge clk);
    end
    start = 1'b0;
    checkOutput("restart ignored record cycle", 32'(arrive), 32'd13);
    checkOutput("restart ignored record addr", 32'(c_mis_addr), 32'd5);
    checkOutput("pre-reset err_count", 32'(c_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset mis_valid", 32'(c_mis_valid), 32'd0);
    checkOutput("async reset busy", 32'(c_busy), 32'd0);
    checkOutput("async reset err_count", 32'(c_err), 32'd0);
    checkOutput("async reset mis fields", {27'd0, c_mis_addr} | c_mis_dut | c_mis_gold, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mis_ready = 1'b1;
    runScan("rescan", 16'h0020, 200, done_cycle, nrec);
    checkOutput("rescan done cycle", 32'(done_cycle), 32'd34);
    checkOutput("rescan records", 32'(nrec), 32'd1);
    checkOutput("rescan err_count", 32'(c_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_golden_checker.md
Name: mem_golden_checker

Overview:
- Hardware counterpart of the simulation memory-compare step: after the single-cycle CPU halts, this block reads data memory word by word and compares each word against a golden-image memory.
- Reports every mismatch as an address/data record on a valid/ready stream, then signals done and pass/fail.
- Sits beside the CPU data RAM on a secondary read port; the golden memory sits on the same address bus.

Parameters:
- WORDS, 1024, number of 32-bit words checked (RAM size / 4); addresses 0..WORDS-1.
- ADDR_W, 10, word-address width; must satisfy 2**ADDR_W >= WORDS.
- DATA_W, 32, data word width.
- STOP_ON_FIRST, 0, when 1, the scan ends after the first mismatch record is accepted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a scan from word 0.
- rd_en  output  1  read strobe to both the DUT RAM port and the golden RAM.
- rd_addr  output  ADDR_W  word address driven to both memories.
- dut_rdata  input  DATA_W  DUT RAM read data, valid exactly one cycle after rd_en.
- gold_rdata  input  DATA_W  golden read data, valid exactly one cycle after rd_en.
- mis_valid  output  1  mismatch record valid.
- mis_ready  input  1  consumer accepts the record.
- mis_addr  output  ADDR_W  word address of the mismatch.
- mis_dut  output  DATA_W  DUT value at that address.
- mis_gold  output  DATA_W  golden value at that address.
- busy  output  1  a scan is in progress.
- done  output  1  scan complete; held high until the next start.
- pass  output  1  valid when done is high; 1 means zero mismatches.
- err_count  output  16  mismatches found; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs read 0: rd_en, rd_addr, mis_valid, mis_addr, mis_dut, mis_gold, busy, done, pass, err_count.
- FSM states: IDLE, READ, CMP, EMIT, DONE.
- IDLE:
  - start=1 -> READ; addr counter=0, err_count=0, done=0, pass=0, busy=1.
- READ:
  - rd_en=1 and rd_addr=addr for exactly one cycle, then -> CMP.
- CMP:
  - rd_en=0; read data is valid this cycle.
  - If dut_rdata != gold_rdata: latch mis_addr=addr, mis_dut and mis_gold; increment err_count (saturating); -> EMIT.
  - Otherwise, if addr == WORDS-1 -> DONE; else addr+1 -> READ.
- EMIT:
  - mis_valid=1; mis_addr, mis_dut and mis_gold stay stable until the handshake (mis_valid & mis_ready).
  - On the handshake cycle mis_valid drops next cycle.
  - After the handshake: if STOP_ON_FIRST=1 or addr == WORDS-1 -> DONE; else addr+1 -> READ.
  - mis_ready held low stalls the scan indefinitely; the scan never drops a record.
  - mis_ready may be high before mis_valid rises.
- DONE:
  - done=1, busy=0; pass = (err_count == 0).
  - start=1 -> clears done and pass, then behaves as start from IDLE.
- Throughput: 2 cycles per matching word. Clean scan latency: start accepted at cycle 0, done rises at cycle 2*WORDS+1.
- start while busy: ignored; no restart, no state change.
- Address counter: never wraps; the scan terminates at WORDS-1 even when 2**ADDR_W > WORDS.
- Reset mid-scan: aborts immediately to the reset state, including mid-EMIT with mis_valid high; no record completes.
- Comparison: full DATA_W bitwise equality; no masking.

Decomposition:
- Shared package (checker_pkg):
  - state enum.
  - Default constants WORDS=1024, ADDR_W=10, DATA_W=32.
  - err_count width constant (16).
- Sub-module mis_record_reg: holds the mismatch record plus valid/ready handshake register.
- The FSM and address counter stay in the top module.

Test Plan:
- Identical memories, WORDS=16, mis_ready=1, pulse start -> no mis_valid; done=1 and pass=1 exactly 33 cycles after start; err_count=0.
- Golden word 5 = 32'h0000_0001, DUT word 5 = 32'h0000_0000 -> one record {addr=5, dut=0, gold=1}; done with pass=0, err_count=1.
- Mismatches at words 0 and 15 (last), mis_ready held low 10 cycles at each record -> record fields stable throughout each stall; both records delivered in order; err_count=2; done asserted after the 2nd handshake.
- STOP_ON_FIRST=1, mismatches at words 3 and 7 -> only addr=3 reported; done right after its handshake; err_count=1.
- start re-pulsed mid-scan -> ignored. Then rst_n pulsed low mid-EMIT -> mis_valid, busy and err_count reach 0 immediately without waiting for a clock edge. Then a fresh start -> full rescan from word 0.
